// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the two requester handshakes and the result handshake of
// alu_share_arbiter.
//
// Handshake rule: a transfer happens on a rising clock edge where both
// valid and ready are high. A requester keeps valid high and its payload
// stable until that edge. Ready never depends on the same channel's valid
// except through the grant choice.
//
// Signals (directions as seen by the arbiter, modport slave):
//   i_req0_valid/dataA/dataB/sel  in   requester 0 operation
//   o_req0_ready                  out  requester 0 accepted when valid
//   i_req1_valid/dataA/dataB/sel  in   requester 1 operation
//   o_req1_ready                  out  requester 1 accepted when valid
//   o_res_valid/o_res_data/o_res_id out result register contents
//   i_res_ready                   in   consumer takes result when valid
// modport master is the producer/consumer side (testbench).
interface alu_share_arbiter_if #(
  parameter int N_BITS = 16
);
  logic              i_req0_valid;
  logic [N_BITS-1:0] i_req0_dataA;
  logic [N_BITS-1:0] i_req0_dataB;
  logic [1:0]        i_req0_sel;
  logic              o_req0_ready;

  logic              i_req1_valid;
  logic [N_BITS-1:0] i_req1_dataA;
  logic [N_BITS-1:0] i_req1_dataB;
  logic [1:0]        i_req1_sel;
  logic              o_req1_ready;

  logic              o_res_valid;
  logic [N_BITS-1:0] o_res_data;
  logic              o_res_id;
  logic              i_res_ready;

  modport slave (
    input  i_req0_valid, i_req0_dataA, i_req0_dataB, i_req0_sel,
    output o_req0_ready,
    input  i_req1_valid, i_req1_dataA, i_req1_dataB, i_req1_sel,
    output o_req1_ready,
    output o_res_valid, o_res_data, o_res_id,
    input  i_res_ready
  );

  modport master (
    output i_req0_valid, i_req0_dataA, i_req0_dataB, i_req0_sel,
    input  o_req0_ready,
    output i_req1_valid, i_req1_dataA, i_req1_dataB, i_req1_sel,
    input  o_req1_ready,
    input  o_res_valid, o_res_data, o_res_id,
    output i_res_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Two requesters share one registered signed ALU (add, sub, AND, OR).
// Round-robin grant between simultaneous requests; every accepted operation
// yields one tagged result in a one-deep output register with backpressure.
//
// Ports:
//   i_clk    in  clock, rising edge
//   i_rst_n  in  asynchronous active-low reset
//   bus      alu_share_arbiter_if.slave (request and result handshakes)
//
// Optional build macro: ALU_SHARE_SAT_EN -- add/sub saturate to the signed
// limits instead of wrapping. AND/OR and latency are unaffected.
module alu_share_arbiter #(
  parameter int N_BITS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  alu_share_arbiter_if.slave     bus
);

  logic              last_served;
  logic              free;
  logic              grant0;
  logic              grant1;
  logic              ready0;
  logic              ready1;
  logic              accept0;
  logic              accept1;
  logic              accept;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic [1:0]        op_sel;
  logic [N_BITS-1:0] alu_y;

  logic              res_valid_q;
  logic [N_BITS-1:0] res_data_q;
  logic              res_id_q;

  // The slot can take a new result if empty or being drained this cycle.
  assign free = !res_valid_q || bus.i_res_ready;

  // Round robin: a lone requester always wins; on contention the one not
  // served last wins. last_served resets to 1 so requester 0 goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      grant0 = last_served;
      grant1 = !last_served;
    end else begin
      grant0 = bus.i_req0_valid;
      grant1 = bus.i_req1_valid;
    end
  end

  // Reset gating keeps both readies low while the block is held in reset.
  assign ready0  = grant0 && free && i_rst_n;
  assign ready1  = grant1 && free && i_rst_n;
  assign accept0 = bus.i_req0_valid && ready0;
  assign accept1 = bus.i_req1_valid && ready1;
  assign accept  = accept0 || accept1;

  assign op_a   = grant1 ? bus.i_req1_dataA : bus.i_req0_dataA;
  assign op_b   = grant1 ? bus.i_req1_dataB : bus.i_req0_dataB;
  assign op_sel = grant1 ? bus.i_req1_sel   : bus.i_req0_sel;

`ifdef ALU_SHARE_SAT_EN
  // One extra bit of headroom: overflow shows as the top two bits differing.
  logic [N_BITS:0] arith;

  always_comb begin
    arith = op_sel[0] ? ({op_a[N_BITS-1], op_a} - {op_b[N_BITS-1], op_b})
                      : ({op_a[N_BITS-1], op_a} + {op_b[N_BITS-1], op_b});
    case (op_sel)
      2'd2:    alu_y = op_a & op_b;
      2'd3:    alu_y = op_a | op_b;
      default: begin
        if (arith[N_BITS] != arith[N_BITS-1]) begin
          alu_y = arith[N_BITS] ? {1'b1, {(N_BITS-1){1'b0}}}
                                : {1'b0, {(N_BITS-1){1'b1}}};
        end else begin
          alu_y = arith[N_BITS-1:0];
        end
      end
    endcase
  end
`else
  logic [N_BITS-1:0] arith;

  always_comb begin
    arith = op_sel[0] ? (op_a - op_b) : (op_a + op_b);
    case (op_sel)
      2'd2:    alu_y = op_a & op_b;
      2'd3:    alu_y = op_a | op_b;
      default: alu_y = arith;
    endcase
  end
`endif

  // Accept takes priority over drain: a drain plus accept on the same edge
  // simply reloads the register with the new result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      last_served <= 1'b1;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_y;
      res_id_q    <= accept1;
      last_served <= accept1;
    end else if (res_valid_q && bus.i_res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.o_req0_ready = ready0;
  assign bus.o_req1_ready = ready1;
  assign bus.o_res_valid  = res_valid_q;
  assign bus.o_res_data   = res_data_q;
  assign bus.o_res_id     = res_id_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single registered 4-op signed ALU (add, sub, AND, OR) between two independent requesters using valid/ready handshakes and round-robin arbitration. It sits between two producer blocks and one result consumer. Each accepted operation produces exactly one tagged result, held in a one-deep output register with backpressure.

## Interface

Parameters:
- N_BITS, 16, operand and result width (signed two's complement), ≥ 2

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_valid  in  1  requester 0 has an operation
- i_req0_dataA  in  N_BITS  requester 0 operand A, signed
- i_req0_dataB  in  N_BITS  requester 0 operand B, signed
- i_req0_sel  in  2  requester 0 op: 0 add, 1 sub (A−B), 2 AND, 3 OR
- o_req0_ready  out  1  requester 0 operation accepted this cycle if valid
- i_req1_valid, i_req1_dataA, i_req1_dataB, i_req1_sel, o_req1_ready: same as requester 0, for requester 1
- o_res_valid  out  1  result register holds a result
- o_res_data  out  N_BITS  result, signed
- o_res_id  out  1  requester that issued this result (0 or 1)
- i_res_ready  in  1  consumer takes result this cycle if o_res_valid

## Operation

- Slot free condition: free = !o_res_valid || i_res_ready.
- Grant (combinational): only one valid requester → it is granted; both valid → requester ≠ last_served; neither → no grant. last_served resets to 1, so requester 0 wins the first contention.
- o_reqX_ready = granted(X) && free. At most one ready is high per cycle. Ready never depends on that requester's own valid beyond grant selection. There is no combinational path from i_res_ready to o_res_data.
- Accept (valid && ready): next edge loads o_res_data = f(A, B, sel), o_res_id = X, o_res_valid = 1, last_served = X.
- No accept and i_res_ready && o_res_valid: o_res_valid ← 0. o_res_data and o_res_id hold their last values.
- No accept and no drain: all registers hold.
- Arithmetic: add/sub are computed N_BITS wide and wrap modulo 2^N_BITS unless saturation is compiled in (see Configuration). AND/OR are bitwise.
- last_served updates only on an accept, never on a stall.
- Requester protocol (checked by the bench, not by RTL): once valid rises, payload stays stable and valid stays high until accepted.

## Timing

- Reset values: o_res_valid = 0, o_res_data = 0, o_res_id = 0, last_served = 1. o_req0_ready and o_req1_ready are 0 while i_rst_n is low.
- Latency: an operation accepted at edge k is visible with o_res_valid = 1 after edge k, i.e. one cycle.
- Throughput: one operation per cycle while i_res_ready is held high. Drain and a new accept in the same cycle are allowed (back-to-back).
- Backpressure: while o_res_valid && !i_res_ready, both readies are 0 and the result is held stable.
- Reset mid-operation: an asynchronous assert clears the result register immediately and drops any pending result. Arbitration restarts with requester 0 priority.

## Configuration

- ALU_SHARE_SAT_EN defined: add/sub saturate to the signed limits 2^(N_BITS−1)−1 and −2^(N_BITS−1) on overflow. AND/OR are unchanged. Latency is unchanged.
- ALU_SHARE_SAT_EN undefined: add/sub wrap two's complement.

## Test plan

- Reset, then req0 {A=5, B=3, sel=0} alone with i_res_ready=1 → accepted first cycle; next cycle o_res_valid=1, data=8, id=0.
- Both requesters valid continuously (req0 sel=1 A=10 B=4; req1 sel=2 A=0x00F0 B=0x0FF0), i_res_ready=1 → results alternate id 0,1,0,1 with data 6, 0x00F0, one result per cycle.
- Result held with i_res_ready=0 for 3 cycles while req1 is valid → both readies are 0, o_res_data is stable; on the ready cycle, drain and accept of req1 occur on the same edge.
- N_BITS=16, A=0x7FFF, B=1, sel=0 → 0x8000 without the macro, 0x7FFF with ALU_SHARE_SAT_EN. A=0x8000, B=1, sel=1 → 0x7FFF without the macro, 0x8000 with it.
- req1 {A=3, B=0xFFFC, sel=3} → 0xFFFF. Then assert i_rst_n low asynchronously while a result is pending → o_res_valid drops before the next edge. After release, with both requesters valid, req0 is granted first.
